tx_order_arbiter: RTL

//  Shares the single Logic->TX message slot between N_REQ order-decision engines.
//  - Round-robin arbitration with a per-requester enable mask.
//  - Holds the granted message stable until TX accepts it.
//  - Enforces a minimum inter-message gap for the TX MAC.
//  - Tags each message with the cycle_cnt value at grant time, for decision-latency measurement.

---
 rtl/lat_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 33 +++
 rtl/tx_order_arbiter.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/lat_pkg.sv
// Shared types for the TX order arbiter: FSM states and the default-width message layout.
// Pure declarations; no logic, no timing.
package lat_pkg;

    localparam int MSG_TYPE_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } arb_state_t;

    // Message layout at the default field widths (64-bit id, 32-bit price and volume).
    typedef struct packed {
        logic [MSG_TYPE_W-1:0] msg_type;
        logic [63:0]           order_id;
        logic [31:0]           price;
        logic [31:0]           volume;
    } order_msg_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first eligible bit searched upward from last_grant+1.
// Zero latency; no state and no backpressure of its own.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  eligible_i,
    input  logic [IW-1:0] last_grant_i,
    output logic [N-1:0]  grant_onehot_o,
    output logic [IW-1:0] grant_idx_o,
    output logic          any_o
);

    always_comb begin
        logic hit;
        int   j;
        hit            = 1'b0;
        j              = 0;
        grant_onehot_o = '0;
        grant_idx_o    = '0;
        for (int k = 0; k < N; k++) begin
            j = (int'(last_grant_i) + 1 + k) % N;
            if (!hit && eligible_i[j]) begin
                hit               = 1'b1;
                grant_onehot_o[j] = 1'b1;
                grant_idx_o       = IW'(j);
            end
        end
    end

    assign any_o = |eligible_i;

endmodule

// File: rtl/tx_order_arbiter.sv
// Shares the single TX message slot among N_REQ engines: grant in IDLE, hold until TX accepts, then optional gap.
// Request seen at t -> out_valid at t+1; message held stable while out_ready is low, req_ready only pulses in IDLE.
module tx_order_arbiter
    import lat_pkg::*;
#(
    parameter  int N_REQ   = 4,
    parameter  int ID_W    = 64,
    parameter  int PX_W    = 32,
    parameter  int QTY_W   = 32,
    parameter  int TS_W    = 32,
    parameter  int MIN_GAP = 0,
    localparam int SRC_W   = $clog2(N_REQ)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [TS_W-1:0]             cycle_cnt,
    input  logic [N_REQ-1:0]            en_mask,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ*MSG_TYPE_W-1:0] req_type,
    input  logic [N_REQ*ID_W-1:0]       req_order_id,
    input  logic [N_REQ*PX_W-1:0]       req_price,
    input  logic [N_REQ*QTY_W-1:0]      req_volume,
    output logic [N_REQ-1:0]            req_ready,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [MSG_TYPE_W-1:0]       out_type,
    output logic [ID_W-1:0]             out_order_id,
    output logic [PX_W-1:0]             out_price,
    output logic [QTY_W-1:0]            out_volume,
    output logic [SRC_W-1:0]            out_src,
    output logic [TS_W-1:0]             out_ts,
    output logic [TS_W-1:0]             issue_cnt,
    output logic                        busy
);

    localparam logic [7:0] GAP_LOAD = (MIN_GAP > 0) ? 8'(MIN_GAP - 1) : 8'd0;

    arb_state_t state_q, state_d;

    logic [N_REQ-1:0]      eligible;
    logic [N_REQ-1:0]      grant_onehot;
    logic [SRC_W-1:0]      grant_idx;
    logic                  grant_any;
    logic                  grant;
    logic                  xfer;

    logic [MSG_TYPE_W-1:0] type_q, type_d;
    logic [ID_W-1:0]       id_q, id_d;
    logic [PX_W-1:0]       px_q, px_d;
    logic [QTY_W-1:0]      vol_q, vol_d;
    logic [SRC_W-1:0]      src_q, src_d;
    logic [SRC_W-1:0]      last_grant_q, last_grant_d;
    logic [TS_W-1:0]       ts_q, ts_d;
    logic [TS_W-1:0]       issue_q, issue_d;
    logic [7:0]            gap_q, gap_d;

    assign eligible = req_valid & en_mask;

    rr_arbiter #(.N(N_REQ)) u_rr (
        .eligible_i     (eligible),
        .last_grant_i   (last_grant_q),
        .grant_onehot_o (grant_onehot),
        .grant_idx_o    (grant_idx),
        .any_o          (grant_any)
    );

    assign grant = (state_q == IDLE) && grant_any;
    assign xfer  = (state_q == ISSUE) && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_any) state_d = ISSUE;
            ISSUE:   if (out_ready) state_d = (MIN_GAP == 0) ? IDLE : GAP;
            GAP:     if (gap_q == 8'd0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // req_ready is masked during reset so a discarded cycle never strobes a requester.
    always_comb begin
        req_ready = (grant && !rst) ? grant_onehot : '0;
        out_valid = (state_q == ISSUE);
        busy      = (state_q != IDLE);
    end

    always_comb begin
        type_d       = type_q;
        id_d         = id_q;
        px_d         = px_q;
        vol_d        = vol_q;
        src_d        = src_q;
        last_grant_d = last_grant_q;
        ts_d         = ts_q;
        issue_d      = issue_q;
        gap_d        = gap_q;
        if (grant) begin
            type_d       = req_type[int'(grant_idx)*MSG_TYPE_W +: MSG_TYPE_W];
            id_d         = req_order_id[int'(grant_idx)*ID_W +: ID_W];
            px_d         = req_price[int'(grant_idx)*PX_W +: PX_W];
            vol_d        = req_volume[int'(grant_idx)*QTY_W +: QTY_W];
            src_d        = grant_idx;
            last_grant_d = grant_idx;
            ts_d         = cycle_cnt;
        end
        if (xfer) begin
            issue_d = issue_q + TS_W'(1);
            gap_d   = GAP_LOAD;
        end else if ((state_q == GAP) && (gap_q != 8'd0)) begin
            gap_d = gap_q - 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            type_q       <= '0;
            id_q         <= '0;
            px_q         <= '0;
            vol_q        <= '0;
            src_q        <= '0;
            last_grant_q <= SRC_W'(N_REQ - 1);
            ts_q         <= '0;
            issue_q      <= '0;
            gap_q        <= '0;
        end else begin
            type_q       <= type_d;
            id_q         <= id_d;
            px_q         <= px_d;
            vol_q        <= vol_d;
            src_q        <= src_d;
            last_grant_q <= last_grant_d;
            ts_q         <= ts_d;
            issue_q      <= issue_d;
            gap_q        <= gap_d;
        end
    end

    assign out_type     = type_q;
    assign out_order_id = id_q;
    assign out_price    = px_q;
    assign out_volume   = vol_q;
    assign out_src      = src_q;
    assign out_ts       = ts_q;
    assign issue_cnt    = issue_q;

endmodule
